instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage that drives the instruction ROM. It owns the program counter, presents `instr_addr` to the combinational ROM and captures the returned word into a registered output slot.
- Hands instructions to decode over a valid/ready handshake.
- Handles branch redirects from execute, detects the halt opcode and drains cleanly before asserting `halted`.

Parameters:
- ROM_SIZE, 512, instruction ROM depth in words.
- INSTR_WIDTH, 9, instruction word width.
- HALT_INSTR, 9'b111000000, opcode that terminates fetch.
- START_ADDR, 0, PC value loaded on reset and on start.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begin fetching at START_ADDR
- instr_addr  out  AW  address to ROM; AW = $clog2(ROM_SIZE)+1
- instr_in  in  INSTR_WIDTH  ROM data; combinational, valid in the same cycle as instr_addr
- out_instr  out  INSTR_WIDTH  registered instruction to decode
- out_pc  out  AW  address out_instr was fetched from
- out_valid  out  1  output slot holds a valid instruction
- out_ready  in  1  decode accepts the slot this cycle
- redirect  in  1  taken branch from execute
- redirect_addr  in  AW  branch target
- halted  out  1  program finished
- fetch_count  out  16  instructions loaded into the slot since start

Behaviour:
- Reset values (synchronous, active-high; takes effect at the next clk edge, overriding everything including a stalled handshake):
  - state = IDLE, pc = START_ADDR
  - out_valid = 0, out_instr = 0, out_pc = 0
  - halted = 0, fetch_count = 0
- instr_addr = pc, combinationally, at all times. The MSB is always 0.
- pc arithmetic: increments modulo ROM_SIZE, so ROM_SIZE-1 is followed by 0. redirect_addr is masked to its low $clog2(ROM_SIZE) bits.
- Slot load condition ("load") in RUN: !out_valid || out_ready. On load:
  - out_instr <= instr_in, out_pc <= pc, out_valid <= 1
  - pc <= pc+1
  - fetch_count++, saturating at 16'hFFFF
- Stall: out_valid && !out_ready holds out_instr, out_pc, pc and fetch_count.
- Slot clear: if out_ready && out_valid and no load occurs that cycle, out_valid <= 0.
- Throughput: 1 instruction/cycle while out_ready = 1.
- Latency: start sampled at edge N gives state RUN after N. The first load (START_ADDR) happens at edge N+1, so out_valid = 1 after N+1.
- FSM:
  - IDLE: out_valid = 0. start -> RUN, pc <= START_ADDR.
  - RUN: loads as above. A load whose instr_in == HALT_INSTR -> DRAIN, pc does not increment.
  - DRAIN: no loads. When the halt word is accepted (out_valid && out_ready) -> HALTED, out_valid <= 0, halted <= 1.
  - HALTED: halted = 1 and outputs are static. start -> RUN, pc <= START_ADDR, halted <= 0, fetch_count <= 0.
- Redirect (RUN or DRAIN only; ignored in IDLE/HALTED):
  - Highest priority: pc <= masked redirect_addr, out_valid <= 0 (flush), state <= RUN.
  - No load and no count increment that cycle, regardless of out_ready.
  - A redirect in DRAIN cancels the pending halt.
- start in RUN or DRAIN: ignored.
- Simultaneous redirect and a halt word on instr_in: redirect wins; the halt is not captured.

Decomposition:
- Package fetch_pkg:
  - typedef enum fetch_state_t {IDLE, RUN, DRAIN, HALTED}
  - default HALT_INSTR constant
  - function addr_width(rom_size) returning $clog2(rom_size)+1
- One natural sub-module: fetch_pc_reg, the pc register with modulo increment, redirect mask and start/reset load.
- FSM and output slot live in instr_fetch.

Test Plan:
1. Reset; start; out_ready = 1; ROM 0..4 = 9'b001000110, ROM[5] = HALT -> out_pc 0,1,2,3,4,5 on consecutive cycles, halted = 1 the cycle after the halt handshake, fetch_count = 6, instr_addr stays 5.
2. Slot holding pc = 2; out_ready = 0 for 3 cycles -> out_instr/out_pc/instr_addr stable (2/3); out_ready = 1 -> next out_pc = 3, no skip or duplicate.
3. Slot holding pc = 10; redirect = 1, redirect_addr = 40 -> next cycle out_valid = 0, following cycle out_pc = 40, fetch_count unchanged across the flush cycle.
4. Halt word in slot (DRAIN), out_ready = 0; redirect to 100 -> halt flushed, state RUN, out_pc = 100 next load, halted stays 0.
5. START_ADDR = 510, ROM_SIZE = 512, no halt -> out_pc 510, 511, 0, 1; redirect_addr = 10'h3FF masked -> fetch from 511.
6. Reset asserted with out_valid = 1, out_ready = 0, state RUN -> after the edge out_valid = 0, state IDLE, instr_addr = START_ADDR, fetch_count = 0, halted = 0; start then restarts normally.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM encoding, the default halt opcode and the address width helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [8:0] DEFAULT_HALT_INSTR = 9'b111000000;

    function automatic int addr_width(input int rom_size);
        return $clog2(rom_size) + 1;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: modulo-ROM_SIZE increment, masked redirect load, start/reset load.
// Updates on the clock edge; priority is reset > redirect > start > increment.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int ROM_SIZE   = 512,
    parameter int START_ADDR = 0,
    localparam int AW = addr_width(ROM_SIZE),
    localparam int PW = AW - 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          redirect,
    input  logic [PW-1:0] redirect_pc,
    input  logic          incr,
    output logic [PW-1:0] pc
);

    localparam logic [PW-1:0] START_PC = PW'(START_ADDR);
    localparam logic [PW-1:0] LAST_PC  = PW'(ROM_SIZE - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= START_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (load_start) begin
            pc <= START_PC;
        end else if (incr) begin
            pc <= (pc == LAST_PC) ? '0 : pc + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the ROM address, captures words into a one-entry output slot.
// One instruction per cycle; slot and pc hold while out_valid && !out_ready.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                     ROM_SIZE    = 512,
    parameter int                     INSTR_WIDTH = 9,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(DEFAULT_HALT_INSTR),
    parameter int                     START_ADDR  = 0,
    localparam int AW = addr_width(ROM_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [AW-1:0]          instr_addr,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [AW-1:0]          out_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_addr,
    output logic                   halted,
    output logic [15:0]            fetch_count
);

    localparam int PW = AW - 1;

    fetch_state_t  state, state_nxt;
    logic [PW-1:0] pc;
    logic          redir_act, load, pc_incr, pc_start, halt_accept, is_halt;
    logic          unused_redirect_msb;

    assign unused_redirect_msb = redirect_addr[AW-1];
    assign instr_addr          = {1'b0, pc};
    assign is_halt             = (instr_in == HALT_INSTR);

    fetch_pc_reg #(
        .ROM_SIZE   (ROM_SIZE),
        .START_ADDR (START_ADDR)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .load_start  (pc_start),
        .redirect    (redir_act),
        .redirect_pc (redirect_addr[PW-1:0]),
        .incr        (pc_incr),
        .pc          (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (redir_act) state_nxt = RUN;
                     else if (load && is_halt) state_nxt = DRAIN;
            DRAIN:   if (redir_act) state_nxt = RUN;
                     else if (halt_accept) state_nxt = HALTED;
            HALTED:  if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // A redirect flushes the slot and suppresses that cycle's load, even with a halt word on instr_in.
    always_comb begin
        redir_act   = redirect && (state == RUN || state == DRAIN);
        load        = (state == RUN) && !redir_act && (!out_valid || out_ready);
        pc_incr     = load && !is_halt;
        pc_start    = start && (state == IDLE || state == HALTED);
        halt_accept = (state == DRAIN) && !redir_act && out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (redir_act) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
                out_instr <= instr_in;
                out_pc    <= {1'b0, pc};
                if (fetch_count != 16'hFFFF) begin
                    fetch_count <= fetch_count + 16'd1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (pc_start) begin
                halted      <= 1'b0;
                fetch_count <= '0;
            end else if (halt_accept) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle table on a START_ADDR=0 instance
// plus a hand sequence on a START_ADDR=510 instance for pc wrap and redirect masking.
module tb_instr_fetch;

    localparam logic [8:0] HALT = 9'b111000000;
    localparam logic [8:0] BODY = 9'b001000110;

    logic       clk;
    logic       reset, start, out_ready, redirect;
    logic [9:0] redirect_addr, instr_addr, out_pc;
    logic [8:0] instr_in, out_instr;
    logic       out_valid, halted;
    logic [15:0] fetch_count;

    logic       reset2, start2, out_ready2, redirect2;
    logic [9:0] redirect_addr2, instr_addr2, out_pc2;
    logic [8:0] instr_in2, out_instr2;
    logic       out_valid2, halted2;
    logic [15:0] fetch_count2;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [8:0] rom_word(input logic [9:0] a);
        if (a == 10'd5) return HALT;
        if (a < 10'd5)  return BODY;
        return {1'b0, a[7:0]};
    endfunction

    function automatic logic [8:0] rom2_word(input logic [9:0] a);
        return {1'b0, a[7:0]};
    endfunction

    assign instr_in  = rom_word(instr_addr);
    assign instr_in2 = rom2_word(instr_addr2);

    instr_fetch #(.ROM_SIZE(512), .INSTR_WIDTH(9), .HALT_INSTR(HALT), .START_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .instr_addr(instr_addr), .instr_in(instr_in),
        .out_instr(out_instr), .out_pc(out_pc), .out_valid(out_valid), .out_ready(out_ready),
        .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted), .fetch_count(fetch_count)
    );

    instr_fetch #(.ROM_SIZE(512), .INSTR_WIDTH(9), .HALT_INSTR(HALT), .START_ADDR(510)) dut2 (
        .clk(clk), .reset(reset2), .start(start2), .instr_addr(instr_addr2), .instr_in(instr_in2),
        .out_instr(out_instr2), .out_pc(out_pc2), .out_valid(out_valid2), .out_ready(out_ready2),
        .redirect(redirect2), .redirect_addr(redirect_addr2), .halted(halted2), .fetch_count(fetch_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst, st, rdy, rd, raddr;
        int evld, epc, eaddr, ehalt, ecnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int rst, input int st, input int rdy, input int rd, input int raddr,
                       input int evld, input int epc, input int eaddr, input int ehalt, input int ecnt);
        vec_t v;
        v.rst = rst; v.st = st; v.rdy = rdy; v.rd = rd; v.raddr = raddr;
        v.evld = evld; v.epc = epc; v.eaddr = eaddr; v.ehalt = ehalt; v.ecnt = ecnt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int step, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
        reset2 = 1'b1; start2 = 1'b0; out_ready2 = 1'b0; redirect2 = 1'b0; redirect_addr2 = '0;

        //  rst st rdy rd raddr | vld pc addr halt cnt
        add(1, 0, 0, 0,   0,     0,   0,   0, 0,  0);   // reset
        add(0, 1, 1, 0,   0,     0,   0,   0, 0,  0);   // start -> RUN
        add(0, 0, 1, 0,   0,     1,   0,   1, 0,  1);
        add(0, 0, 1, 0,   0,     1,   1,   2, 0,  2);
        add(0, 0, 1, 0,   0,     1,   2,   3, 0,  3);
        add(0, 0, 1, 0,   0,     1,   3,   4, 0,  4);
        add(0, 0, 1, 0,   0,     1,   4,   5, 0,  5);
        add(0, 0, 1, 0,   0,     1,   5,   5, 0,  6);   // halt captured, pc holds
        add(0, 0, 1, 0,   0,     0,   5,   5, 1,  6);   // halt accepted
        add(0, 0, 1, 1,  30,     0,   5,   5, 1,  6);   // redirect ignored in HALTED
        add(0, 1, 1, 0,   0,     0,   5,   0, 0,  0);   // restart from HALTED
        add(0, 0, 1, 0,   0,     1,   0,   1, 0,  1);
        add(0, 0, 1, 0,   0,     1,   1,   2, 0,  2);
        add(0, 0, 1, 0,   0,     1,   2,   3, 0,  3);   // slot holds pc 2
        add(0, 0, 0, 0,   0,     1,   2,   3, 0,  3);   // stall x3
        add(0, 0, 0, 0,   0,     1,   2,   3, 0,  3);
        add(0, 0, 0, 0,   0,     1,   2,   3, 0,  3);
        add(0, 0, 1, 0,   0,     1,   3,   4, 0,  4);   // no skip or duplicate
        add(0, 0, 1, 1,   8,     0,   3,   8, 0,  4);
        add(0, 0, 1, 0,   0,     1,   8,   9, 0,  5);
        add(0, 0, 1, 0,   0,     1,   9,  10, 0,  6);
        add(0, 0, 1, 0,   0,     1,  10,  11, 0,  7);   // slot holds pc 10
        add(0, 0, 1, 1,  40,     0,  10,  40, 0,  7);   // flush, count held
        add(0, 0, 1, 0,   0,     1,  40,  41, 0,  8);
        add(0, 0, 1, 1,   4,     0,  40,   4, 0,  8);
        add(0, 0, 0, 0,   0,     1,   4,   5, 0,  9);   // empty slot loads despite !ready
        add(0, 0, 1, 0,   0,     1,   5,   5, 0, 10);   // halt in slot, DRAIN
        add(0, 0, 0, 0,   0,     1,   5,   5, 0, 10);
        add(0, 0, 0, 1, 100,     0,   5, 100, 0, 10);   // redirect cancels halt
        add(0, 0, 0, 0,   0,     1, 100, 101, 0, 11);
        add(0, 0, 1, 0,   0,     1, 101, 102, 0, 12);
        add(0, 0, 0, 0,   0,     1, 101, 102, 0, 12);   // stalled, RUN
        add(1, 0, 0, 0,   0,     0,   0,   0, 0,  0);   // reset overrides stall
        add(0, 0, 1, 1,  50,     0,   0,   0, 0,  0);   // redirect ignored in IDLE
        add(0, 1, 1, 0,   0,     0,   0,   0, 0,  0);
        add(0, 0, 1, 0,   0,     1,   0,   1, 0,  1);
        add(0, 1, 1, 0,   0,     1,   1,   2, 0,  2);   // start ignored in RUN
        add(0, 0, 1, 1,   5,     0,   1,   5, 0,  2);
        add(0, 0, 1, 1,  20,     0,   1,  20, 0,  2);   // redirect beats halt on instr_in
        add(0, 0, 1, 0,   0,     1,  20,  21, 0,  3);

        #1;
        for (int i = 0; i < vq.size(); i++) begin
            reset         = vq[i].rst[0];
            start         = vq[i].st[0];
            out_ready     = vq[i].rdy[0];
            redirect      = vq[i].rd[0];
            redirect_addr = 10'(vq[i].raddr);
            tick();
            check("out_valid",   i, int'(out_valid),   vq[i].evld);
            check("out_pc",      i, int'(out_pc),      vq[i].epc);
            check("instr_addr",  i, int'(instr_addr),  vq[i].eaddr);
            check("halted",      i, int'(halted),      vq[i].ehalt);
            check("fetch_count", i, int'(fetch_count), vq[i].ecnt);
            if (vq[i].evld != 0)
                check("out_instr", i, int'(out_instr), int'(rom_word(10'(vq[i].epc))));
            if (vq[i].rst != 0)
                check("reset_instr", i, int'(out_instr), 0);
        end
        reset = 1'b0; start = 1'b0; redirect = 1'b0;

        // START_ADDR = 510: wrap from 511 to 0 and masked redirect
        tick();
        check("w_rst_addr", 0, int'(instr_addr2), 510);
        reset2 = 1'b0; start2 = 1'b1; out_ready2 = 1'b1;
        tick();
        check("w_start_vld", 1, int'(out_valid2), 0);
        start2 = 1'b0;
        tick();
        check("w_pc510", 2, int'(out_pc2), 510);
        check("w_instr510", 2, int'(out_instr2), int'(rom2_word(10'd510)));
        tick();
        check("w_pc511", 3, int'(out_pc2), 511);
        check("w_addr_wrap", 3, int'(instr_addr2), 0);
        tick();
        check("w_pc0", 4, int'(out_pc2), 0);
        tick();
        check("w_pc1", 5, int'(out_pc2), 1);
        redirect2 = 1'b1; redirect_addr2 = 10'h3FF;
        tick();
        check("w_redir_vld", 6, int'(out_valid2), 0);
        check("w_redir_mask", 6, int'(instr_addr2), 511);
        redirect2 = 1'b0;
        tick();
        check("w_pc_redir", 7, int'(out_pc2), 511);
        check("w_addr_after", 7, int'(instr_addr2), 0);
        check("w_count", 7, int'(fetch_count2), 5);
        check("w_halted", 7, int'(halted2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
